// File: rtl/spi_pkg.sv
// Shared types for the SPI master: FSM state encoding, mode constants, clog2 helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD,
        TERM
    } spi_state_e;

    // SPI modes encoded as {cpol, cpha}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    // Ceiling log2, used for constant width calculations
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SPI clock generator: half-period counter, sclk register, leading/trailing edge strobes.
// Latency: first strobe div+1 cycles after en rises; sclk toggles on the edge ending a strobe cycle.
// Backpressure: none; en low parks sclk at start_lvl and clears the counter.
module spi_clk_gen #(
    parameter int DIV_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start_lvl,
    input  logic [DIV_W-1:0] div,
    output logic             sclk,
    output logic             lead_edge,
    output logic             trail_edge
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             sclk_q, sclk_d;

    // Next counter/sclk value and edge strobes; a strobe marks the cycle before sclk moves
    always_comb begin
        cnt_d      = cnt_q;
        sclk_d     = sclk_q;
        lead_edge  = 1'b0;
        trail_edge = 1'b0;
        if (!en) begin
            cnt_d  = '0;
            sclk_d = start_lvl;
        end else if (cnt_q == div) begin
            cnt_d  = '0;
            sclk_d = ~sclk_q;
            // Moving away from the idle level is the leading edge
            if (sclk_q == start_lvl) begin
                lead_edge = 1'b1;
            end else begin
                trail_edge = 1'b1;
            end
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    // Counter and sclk registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk = sclk_q;

endmodule

// File: rtl/spi_master_gen.sv
// SPI master, all four modes, MSB/LSB first, runtime divider, multi-word frames with ss_n held.
// Latency: accept edge to rx_valid = (2*DATA_W+1)*(div+1) cycles from IDLE, 2*DATA_W*(div+1) from HOLD.
// Backpressure: tx_ready high only in IDLE/HOLD; tx_valid ignored while a word is in flight.
module spi_master_gen import spi_pkg::*; #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIV_W-1:0]  div,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_last,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              ss_n,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso
);

    localparam int                EDGE_W  = clog2(2 * DATA_W + 1);
    localparam logic [EDGE_W-1:0] LAST_M1 = EDGE_W'(2 * DATA_W - 1);

    spi_state_e        state_q, state_d;
    logic [DIV_W-1:0]  wait_q, wait_d;
    logic [EDGE_W-1:0] edge_q, edge_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              mosi_q, mosi_d;
    logic              ss_n_q, ss_n_d;
    logic              tx_ready_q, tx_ready_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              cpol_q, cpol_d;
    logic              cpha_q, cpha_d;
    logic              lsb_q, lsb_d;
    logic              last_q, last_d;

    logic              accept;
    logic              clk_en;
    logic              start_lvl;
    logic              lead_edge;
    logic              trail_edge;
    logic              sample_now;
    logic              drive_now;

    function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b,
                                                    input logic lsb);
        return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
    endfunction

    // In IDLE sclk follows the live cpol; afterwards the frozen copy
    assign clk_en    = (state_q == XFER);
    assign start_lvl = (state_q == IDLE) ? cpol : cpol_q;

    spi_clk_gen #(
        .DIV_W(DIV_W)
    ) u_clk_gen (
        .clk       (clk),
        .rst       (rst),
        .en        (clk_en),
        .start_lvl (start_lvl),
        .div       (div_q),
        .sclk      (sclk),
        .lead_edge (lead_edge),
        .trail_edge(trail_edge)
    );

    assign accept     = tx_valid && tx_ready_q;
    // cpha=0 samples on leading edges; cpha=1 samples on trailing edges
    assign sample_now = cpha_q ? trail_edge : lead_edge;
    // The final trailing edge of a cpha=0 word carries no new bit
    assign drive_now  = cpha_q ? lead_edge : (trail_edge && (edge_q != LAST_M1));

    // Next-state, shift and output logic
    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        edge_d     = edge_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        mosi_d     = mosi_q;
        ss_n_d     = ss_n_q;
        div_d      = div_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        lsb_d      = lsb_q;
        last_d     = last_q;

        case (state_q)
            IDLE: begin
                mosi_d = 1'b1;
                ss_n_d = 1'b1;
                if (accept) begin
                    div_d   = div;
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    lsb_d   = lsb_first;
                    last_d  = tx_last;
                    ss_n_d  = 1'b0;
                    wait_d  = '0;
                    edge_d  = '0;
                    state_d = SETUP;
                    if (!cpha) begin
                        mosi_d  = first_bit(tx_data, lsb_first);
                        tx_sh_d = shift_out(tx_data, lsb_first);
                    end else begin
                        tx_sh_d = tx_data;
                    end
                end
            end
            SETUP: begin
                if (wait_q == div_q) begin
                    wait_d  = '0;
                    state_d = XFER;
                end else begin
                    wait_d = wait_q + DIV_W'(1);
                end
            end
            XFER: begin
                if (lead_edge || trail_edge) begin
                    edge_d = edge_q + EDGE_W'(1);
                end
                if (sample_now) begin
                    rx_sh_d = shift_in(rx_sh_q, miso, lsb_q);
                end
                if (drive_now) begin
                    mosi_d  = first_bit(tx_sh_q, lsb_q);
                    tx_sh_d = shift_out(tx_sh_q, lsb_q);
                end
                if ((lead_edge || trail_edge) && (edge_q == LAST_M1)) begin
                    rx_data_d  = rx_sh_d;
                    rx_valid_d = 1'b1;
                    wait_d     = '0;
                    state_d    = last_q ? TERM : HOLD;
                end
            end
            HOLD: begin
                if (accept) begin
                    last_d  = tx_last;
                    edge_d  = '0;
                    state_d = XFER;
                    if (!cpha_q) begin
                        mosi_d  = first_bit(tx_data, lsb_q);
                        tx_sh_d = shift_out(tx_data, lsb_q);
                    end else begin
                        tx_sh_d = tx_data;
                    end
                end
            end
            TERM: begin
                if (wait_q == div_q) begin
                    wait_d  = '0;
                    ss_n_d  = 1'b1;
                    mosi_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        tx_ready_d = (state_d == IDLE) || (state_d == HOLD);
    end

    // State and datapath registers; reset forces pins to their idle levels at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_q     <= '0;
            edge_q     <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            mosi_q     <= 1'b1;
            ss_n_q     <= 1'b1;
            tx_ready_q <= 1'b0;
            div_q      <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            edge_q     <= edge_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            mosi_q     <= mosi_d;
            ss_n_q     <= ss_n_d;
            tx_ready_q <= tx_ready_d;
            div_q      <= div_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            lsb_q      <= lsb_d;
            last_q     <= last_d;
        end
    end

    assign tx_ready = tx_ready_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = (state_q != IDLE);
    assign ss_n     = ss_n_q;
    assign mosi     = mosi_q;

endmodule

// File: tb/tb_spi_master_gen.sv
// Bench for spi_master_gen: scoreboard of expected words against a bus-level slave/monitor.
// Latency: checks word time and sclk period against the divider formula.
// Backpressure: drives tx_valid and waits (bounded) on tx_ready.
module tb_spi_master_gen;

    localparam int DATA_W = 8;
    localparam int DIV_W  = 12;

    typedef struct {
        logic [7:0] rx;
        logic [7:0] tx;
        int         acc;
        int         lat;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [DIV_W-1:0]  div;
    logic              cpol, cpha, lsb_first;
    logic [DATA_W-1:0] tx_data;
    logic              tx_last, tx_valid, tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid, busy, ss_n, sclk, mosi, miso;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t sb[$];

    // Bench-side view of the configuration frozen at the start of a word
    int   div_t;
    bit   cpol_t, cpha_t, lsb_t;

    // Slave model state
    bit         loop_en;
    logic [7:0] slv_word, slv_sh;
    logic       miso_s;

    // Monitor state
    logic       prev_ss, prev_sclk;
    int         mon_edges, lead_cnt, last_lead, rx_cnt, ss_rise;
    logic [7:0] mon_word;
    bit         is_lead;
    exp_t       mon_e;

    assign miso = loop_en ? mosi : miso_s;

    spi_master_gen #(
        .DATA_W(DATA_W),
        .DIV_W (DIV_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .div      (div),
        .cpol     (cpol),
        .cpha     (cpha),
        .lsb_first(lsb_first),
        .tx_data  (tx_data),
        .tx_last  (tx_last),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .busy     (busy),
        .ss_n     (ss_n),
        .sclk     (sclk),
        .mosi     (mosi),
        .miso     (miso)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic cfg(input int d, input bit pol, input bit pha, input bit lsb);
        div       = DIV_W'(d);
        cpol      = pol;
        cpha      = pha;
        lsb_first = lsb;
        div_t     = d;
        cpol_t    = pol;
        cpha_t    = pha;
        lsb_t     = lsb;
    endtask

    // Offer one word, push its expectation on acceptance, return on the following negedge
    task automatic send(input logic [7:0] d, input logic last, input logic [7:0] exp_rx,
                        input bit keep);
        exp_t e;
        int   n;
        tx_data  = d;
        tx_last  = last;
        tx_valid = 1'b1;
        n = 0;
        while (!tx_ready && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready) begin
            check_val("accept_timeout", 64'd0, 64'd1);
            tx_valid = 1'b0;
            return;
        end
        e.rx  = exp_rx;
        e.tx  = d;
        e.acc = cyc + 1;
        e.lat = busy ? 2 * DATA_W * (div_t + 1) : (2 * DATA_W + 1) * (div_t + 1);
        sb.push_back(e);
        @(negedge clk);
        if (!keep) tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check_val("idle_timeout", busy, 1'b0);
        @(negedge clk);
    endtask

    // Bus monitor and slave: watches sclk edges at negedge, captures mosi, drives miso
    always @(negedge clk) begin
        if (rst) begin
            prev_ss   = 1'b1;
            prev_sclk = sclk;
            mon_edges = 0;
            lead_cnt  = 0;
        end else begin
            if (prev_ss && !ss_n) begin
                mon_edges = 0;
                lead_cnt  = 0;
                mon_word  = '0;
                slv_sh    = slv_word;
                if (!cpha_t) begin
                    miso_s = lsb_t ? slv_sh[0] : slv_sh[7];
                    slv_sh = lsb_t ? (slv_sh >> 1) : (slv_sh << 1);
                end
            end
            if (!ss_n && (sclk != prev_sclk)) begin
                mon_edges++;
                is_lead = (sclk != cpol_t);
                if (is_lead) begin
                    if (lead_cnt > 0) check_val("sclk_period", cyc - last_lead, 2 * (div_t + 1));
                    last_lead = cyc;
                    lead_cnt++;
                end
                if (is_lead != cpha_t) begin
                    mon_word = lsb_t ? {mosi, mon_word[7:1]} : {mon_word[6:0], mosi};
                end else begin
                    miso_s = lsb_t ? slv_sh[0] : slv_sh[7];
                    slv_sh = lsb_t ? (slv_sh >> 1) : (slv_sh << 1);
                end
            end
            if (rx_valid) begin
                if (sb.size() == 0) begin
                    check_val("rx_unexpected", 64'd1, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check_val("rx_data", rx_data, mon_e.rx);
                    check_val("mosi_word", mon_word, mon_e.tx);
                    check_val("word_time", cyc - mon_e.acc, mon_e.lat);
                    check_val("lead_edges", lead_cnt, DATA_W);
                    check_val("sclk_rest", sclk, cpol_t);
                    check_val("ss_low_at_rx", ss_n, 1'b0);
                end
                rx_cnt++;
                lead_cnt = 0;
                mon_word = '0;
            end
            if (!prev_ss && ss_n) ss_rise++;
            prev_ss   = ss_n;
            prev_sclk = sclk;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rx0, ss0, n;
        rst       = 1'b1;
        tx_data   = '0;
        tx_last   = 1'b0;
        tx_valid  = 1'b0;
        loop_en   = 1'b1;
        slv_word  = '0;
        slv_sh    = '0;
        miso_s    = 1'b0;
        mon_word  = '0;
        rx_cnt    = 0;
        ss_rise   = 0;
        last_lead = 0;
        cfg(1, 1'b0, 1'b0, 1'b0);
        #3;
        check_val("rst_ss_n", ss_n, 1'b1);
        check_val("rst_sclk", sclk, 1'b0);
        check_val("rst_mosi", mosi, 1'b1);
        check_val("rst_tx_ready", tx_ready, 1'b0);
        check_val("rst_rx_valid", rx_valid, 1'b0);
        check_val("rst_rx_data", rx_data, 8'h00);
        check_val("rst_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("idle_tx_ready", tx_ready, 1'b1);

        // Mode 0, MSB first, loopback
        send(8'hA5, 1'b1, 8'hA5, 1'b0);
        wait_idle();
        check_val("t1_ss_n_idle", ss_n, 1'b1);
        check_val("t1_mosi_idle", mosi, 1'b1);
        check_val("t1_sclk_idle", sclk, 1'b0);

        // Mode 3, slave returns 0xC3
        cfg(1, 1'b1, 1'b1, 1'b0);
        loop_en  = 1'b0;
        slv_word = 8'hC3;
        rx0      = rx_cnt;
        @(negedge clk);
        check_val("t2_sclk_idle", sclk, 1'b1);
        send(8'h3C, 1'b1, 8'hC3, 1'b0);
        wait_idle();
        check_val("t2_rx_pulses", rx_cnt - rx0, 1);

        // Mode 1, LSB first, slave returns 0x80
        cfg(2, 1'b0, 1'b1, 1'b1);
        slv_word = 8'h80;
        @(negedge clk);
        send(8'h01, 1'b1, 8'h80, 1'b0);
        wait_idle();

        // Three-word frame with tx_valid held
        cfg(1, 1'b0, 1'b0, 1'b0);
        loop_en = 1'b1;
        rx0     = rx_cnt;
        ss0     = ss_rise;
        @(negedge clk);
        send(8'h11, 1'b0, 8'h11, 1'b1);
        send(8'h22, 1'b0, 8'h22, 1'b1);
        send(8'h33, 1'b1, 8'h33, 1'b0);
        wait_idle();
        check_val("t4_rx_pulses", rx_cnt - rx0, 3);
        check_val("t4_ss_rise", ss_rise - ss0, 1);

        // Fastest divider, then slow divider with inputs disturbed mid-word
        cfg(0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        send(8'h5A, 1'b1, 8'h5A, 1'b0);
        wait_idle();
        cfg(499, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        send(8'h96, 1'b1, 8'h96, 1'b0);
        div       = DIV_W'(7);
        cpha      = 1'b1;
        lsb_first = 1'b1;
        wait_idle();

        // Reset in the middle of a word
        cfg(1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        send(8'hC7, 1'b1, 8'hC7, 1'b0);
        n = 0;
        while (mon_edges < 7 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_val("t6_edge7_seen", (mon_edges >= 7), 1'b1);
        rst = 1'b1;
        #1;
        check_val("t6_ss_n", ss_n, 1'b1);
        check_val("t6_sclk", sclk, 1'b0);
        check_val("t6_mosi", mosi, 1'b1);
        check_val("t6_busy", busy, 1'b0);
        check_val("t6_rx_data", rx_data, 8'h00);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(8'h4E, 1'b1, 8'h4E, 1'b0);
        wait_idle();

        check_val("sb_empty", sb.size(), 0);
        check_val("rx_total", rx_cnt, 9);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
